// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam int unsigned PORT_CPU     = 0;
    localparam int unsigned PORT_DMA     = 1;
    localparam int unsigned LOCK_MAX_DEF = 16;

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin picker: prio=0 favours port 0, prio=1 favours port 1.
module dmem_arb_rr (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // A lone requester always wins; on contention the favoured port wins.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~prio);
        gnt[1] = req[1] & (~req[0] |  prio);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and DMA/debug access to a dmem with a registered read port,
// with optional bus locking bounded by LOCK_MAX consecutive grants.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q;
    logic             prio_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_valid_q;
    logic             rsp_owner_q;

    logic [1:0] req_v;
    logic [1:0] rr_gnt;
    logic [1:0] gnt_v;
    logic       acc;
    logic       sel_port;
    logic       sel_we;
    logic       sel_lock;
    logic       release_lock;

    assign req_v = {req1, req0};

    dmem_arb_rr u_rr (
        .req  (req_v),
        .prio (prio_q),
        .gnt  (rr_gnt)
    );

    // Grant: round-robin in ARB, owner-only while locked, nothing in reset.
    always_comb begin
        gnt_v = 2'b00;
        if (rst_n) begin
            case (state_q)
                ARB:     gnt_v = rr_gnt;
                LOCK0:   gnt_v = {1'b0, req0};
                LOCK1:   gnt_v = {req1, 1'b0};
                default: gnt_v = 2'b00;
            endcase
        end
    end

    assign gnt0 = gnt_v[0];
    assign gnt1 = gnt_v[1];

    // Route the granted port onto the memory bus; idle bus is all zero.
    always_comb begin
        acc      = 1'b0;
        sel_port = 1'b0;
        sel_we   = 1'b0;
        sel_lock = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (gnt_v[0]) begin
            acc      = 1'b1;
            sel_we   = we0;
            sel_lock = lock0;
            mem_addr = addr0;
            mem_din  = wdata0;
            mem_we   = we0;
        end else if (gnt_v[1]) begin
            acc      = 1'b1;
            sel_port = 1'b1;
            sel_we   = we1;
            sel_lock = lock1;
            mem_addr = addr1;
            mem_din  = wdata1;
            mem_we   = we1;
        end
    end

    // Lock ends on an unlocked grant or once the counter hits LOCK_MAX.
    assign release_lock = ~sel_lock | ((32'(cnt_q) + 32'd1) >= LOCK_MAX);

    // Arbiter FSM, priority pointer, lock counter and read-response stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
        end else begin
            rsp_valid_q <= acc & ~sel_we;
            rsp_owner_q <= sel_port;
            if (acc) begin
                case (state_q)
                    ARB: begin
                        prio_q <= ~sel_port;
                        if (sel_lock && (LOCK_MAX > 1)) begin
                            state_q <= sel_port ? LOCK1 : LOCK0;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    default: begin
                        if (release_lock) begin
                            state_q <= ARB;
                            prio_q  <= ~sel_port;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Read data follows dmem's registered output only for the owning port.
    assign rvalid0 = rsp_valid_q & ~rsp_owner_q;
    assign rvalid1 = rsp_valid_q &  rsp_owner_q;
    assign rdata0  = rvalid0 ? mem_dout : '0;
    assign rdata1  = rvalid1 ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a dmem model and a read-response scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic        load;
    logic [31:0] mem     [4096];
    logic [31:0] ref_mem [4096];

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    // dmem model: registered read returning pre-write contents.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
            mem_dout <= 32'h0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check last cycle's response, drive this cycle, check grant and bus.
    task automatic cycle(input string tag, input logic rst,
                         input logic r0, input logic w0, input logic l0,
                         input logic [11:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input logic [11:0] a1, input logic [31:0] d1,
                         input logic [1:0] eg);
        logic [1:0]  exp_rv;
        logic [31:0] exp_rd0, exp_rd1, exp_din;
        logic [11:0] exp_addr;
        logic        exp_we;
        rsp_t        e;
        @(posedge clk);
        #1;
        exp_rv = 2'b00; exp_rd0 = 32'h0; exp_rd1 = 32'h0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port) begin exp_rv[1] = 1'b1; exp_rd1 = e.data; end
            else        begin exp_rv[0] = 1'b1; exp_rd0 = e.data; end
        end
        chk({tag, ":rvalid"}, 64'({rvalid1, rvalid0}), 64'(exp_rv));
        chk({tag, ":rdata0"}, 64'(rdata0), 64'(exp_rd0));
        chk({tag, ":rdata1"}, 64'(rdata1), 64'(exp_rd1));
        rst_n = rst;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        #1;
        exp_addr = 12'h0; exp_we = 1'b0; exp_din = 32'h0;
        if (eg[0])      begin exp_addr = a0; exp_we = w0; exp_din = d0; end
        else if (eg[1]) begin exp_addr = a1; exp_we = w1; exp_din = d1; end
        chk({tag, ":gnt"},      64'({gnt1, gnt0}), 64'(eg));
        chk({tag, ":mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        chk({tag, ":mem_we"},   64'(mem_we), 64'(exp_we));
        chk({tag, ":mem_din"},  64'(mem_din), 64'(exp_din));
        if (eg[0]) begin
            if (w0) ref_mem[a0] = d0;
            else    sb.push_back('{1'b0, ref_mem[a0]});
        end else if (eg[1]) begin
            if (w1) ref_mem[a1] = d1;
            else    sb.push_back('{1'b1, ref_mem[a1]});
        end
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        load = 1'b1; rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = 12'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = 12'h0; wdata1 = 32'h0;

        // Reset: requests (including a write) must not be granted or reach memory.
        cycle("rst_a", 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 1'b1, 1'b1, 1'b0, 12'h020, 32'h1234, 2'b00);
        cycle("rst_b", 1'b0, 1'b1, 1'b0, 1'b1, 12'h010, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
        cycle("rst_c", 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
        load = 1'b0;
        chk("rst_state", 64'(dut.state_q), 64'(ARB));

        // Single read of 0x010.
        cycle("rd0", 1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b01);
        idle("rd0_rsp");

        // Alternation after a fresh reset.
        cycle("alt_rst", 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 2'b00);
        cycle("alt1", 1'b1, 1'b1, 1'b0, 1'b0, 12'h100, 32'h0, 1'b1, 1'b0, 1'b0, 12'h200, 32'h0, 2'b01);
        cycle("alt2", 1'b1, 1'b1, 1'b0, 1'b0, 12'h101, 32'h0, 1'b1, 1'b0, 1'b0, 12'h201, 32'h0, 2'b10);
        cycle("alt3", 1'b1, 1'b1, 1'b0, 1'b0, 12'h102, 32'h0, 1'b1, 1'b0, 1'b0, 12'h202, 32'h0, 2'b01);
        cycle("alt4", 1'b1, 1'b1, 1'b0, 1'b0, 12'h103, 32'h0, 1'b1, 1'b0, 1'b0, 12'h203, 32'h0, 2'b10);
        idle("alt_rsp");

        // Port 1 write then read-back of the top address.
        cycle("wr1", 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 12'hFFF, 32'h00000055, 2'b10);
        cycle("rd1", 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 12'hFFF, 32'h0, 2'b10);
        idle("rd1_rsp");

        // Three locked reads then one unlocked read while port 1 waits.
        cycle("lk1", 1'b1, 1'b1, 1'b0, 1'b1, 12'h030, 32'h0, 1'b1, 1'b0, 1'b0, 12'h300, 32'h0, 2'b01);
        cycle("lk2", 1'b1, 1'b1, 1'b0, 1'b1, 12'h031, 32'h0, 1'b1, 1'b0, 1'b0, 12'h300, 32'h0, 2'b01);
        cycle("lk3", 1'b1, 1'b1, 1'b0, 1'b1, 12'h032, 32'h0, 1'b1, 1'b0, 1'b0, 12'h300, 32'h0, 2'b01);
        cycle("lk4", 1'b1, 1'b1, 1'b0, 1'b0, 12'h033, 32'h0, 1'b1, 1'b0, 1'b0, 12'h300, 32'h0, 2'b01);
        cycle("lk5", 1'b1, 1'b1, 1'b0, 1'b0, 12'h034, 32'h0, 1'b1, 1'b0, 1'b0, 12'h300, 32'h0, 2'b10);

        // Forced release at LOCK_MAX=4, with an idle owner cycle that must not count.
        cycle("fr1", 1'b1, 1'b1, 1'b0, 1'b1, 12'h040, 32'h0, 1'b1, 1'b0, 1'b0, 12'h400, 32'h0, 2'b01);
        cycle("fr2", 1'b1, 1'b1, 1'b0, 1'b1, 12'h041, 32'h0, 1'b1, 1'b0, 1'b0, 12'h400, 32'h0, 2'b01);
        cycle("fr3", 1'b1, 1'b0, 1'b0, 1'b1, 12'h042, 32'h0, 1'b1, 1'b0, 1'b0, 12'h400, 32'h0, 2'b00);
        cycle("fr4", 1'b1, 1'b1, 1'b0, 1'b1, 12'h043, 32'h0, 1'b1, 1'b0, 1'b0, 12'h400, 32'h0, 2'b01);
        cycle("fr5", 1'b1, 1'b1, 1'b0, 1'b1, 12'h044, 32'h0, 1'b1, 1'b0, 1'b0, 12'h400, 32'h0, 2'b01);
        cycle("fr6", 1'b1, 1'b1, 1'b0, 1'b1, 12'h045, 32'h0, 1'b1, 1'b0, 1'b0, 12'h401, 32'h0, 2'b10);
        idle("fr_rsp");

        // Reset while locked with a port 0 read presented.
        cycle("mr1", 1'b1, 1'b1, 1'b0, 1'b1, 12'h050, 32'h0, 1'b1, 1'b0, 1'b0, 12'h500, 32'h0, 2'b01);
        cycle("mr2", 1'b0, 1'b1, 1'b0, 1'b1, 12'h051, 32'h0, 1'b1, 1'b0, 1'b0, 12'h500, 32'h0, 2'b00);
        cycle("mr3", 1'b1, 1'b1, 1'b0, 1'b0, 12'h052, 32'h0, 1'b1, 1'b0, 1'b0, 12'h501, 32'h0, 2'b01);
        chk("mr_state", 64'(dut.state_q), 64'(ARB));
        idle("mr_rsp");
        idle("drain");
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12: the word address width, matching dmem.
REQ-002 The block SHALL have parameter DATA_W, default 32: the data width.
REQ-003 The block SHALL have parameter LOCK_MAX, default 16: the maximum number of consecutive locked grants to one port.
REQ-004 The block SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-006 For each requester p (p=0 CPU, p=1 DMA/debug), the block SHALL have these ports: reqP in 1; weP in 1; lockP in 1; addrP in ADDR_W; wdataP in DATA_W; gntP out 1; rvalidP out 1; rdataP out DATA_W.
REQ-007 The block SHALL have ports mem_addr out ADDR_W, mem_we out 1, mem_din out DATA_W, and mem_dout in DATA_W: these connect to dmem, which has a registered read.

Function
REQ-008 The block SHALL grant at most one request per cycle; gntP is combinational from the current-cycle reqP and the arbiter state, and a request is accepted in the cycle where reqP and gntP are both high.
REQ-009 When port p is granted, the block SHALL drive mem_addr=addrP, mem_din=wdataP and mem_we=weP in that same cycle; with no grant, the outputs SHALL be mem_we=0 and mem_addr/mem_din=0.
REQ-010 The block SHALL use round-robin arbitration in state ARB: if only one port requests, that port wins; if both request, the port not granted most recently wins; the priority pointer updates only on an accepted grant.
REQ-011 For an accepted read, the block SHALL assert rvalidP for exactly one cycle, the next cycle, with rdataP=mem_dout; accepted writes SHALL produce no rvalid.
REQ-012 While rvalidP is low, rdataP SHALL be 0; the non-owner's rdata SHALL always be 0.
REQ-013 The block SHALL implement these FSM states: ARB, LOCK0, LOCK1.
REQ-014 In ARB, an accepted grant to port p with lockP=1 SHALL move the FSM to LOCKp and load the lock counter with 1.
REQ-015 In LOCKp, only port p SHALL be granted, and the other port's request SHALL wait without being lost (gnt low).
REQ-016 In LOCKp, an accepted grant with lockP=0 SHALL return the FSM to ARB and set the pointer to favour the other port.
REQ-017 In LOCKp, cycles where reqP is low SHALL keep the FSM in LOCKp and leave the counter unchanged.
REQ-018 In LOCKp, each accepted grant with lockP=1 SHALL increment the counter; when the counter reaches LOCK_MAX, the FSM SHALL return to ARB after that grant and the pointer SHALL favour the other port (forced release).
REQ-019 Back-to-back accepted operations SHALL run at full throughput of 1 per cycle.
REQ-020 For a read accepted the cycle after a write to the same address, the block SHALL return the new data.
REQ-021 For a read accepted in the same cycle as a write, the block SHALL return the pre-write data, per dmem behaviour, with no forwarding.
REQ-022 The lock counter width SHALL be clog2(LOCK_MAX+1) bits and SHALL never wrap.

Reset
REQ-023 While rst_n=0 at a clock edge, the block SHALL reset to: FSM=ARB, pointer favours port 0, lock counter=0, the pending-read pipeline cleared, and rvalid0=rvalid1=0 on the following cycle.
REQ-024 While rst_n=0, the block SHALL force gnt0=gnt1=0 and mem_we=0, so that no memory write occurs during reset.
REQ-025 A read accepted in the cycle reset is asserted SHALL produce no rvalid.
REQ-026 The block SHALL need no initial values beyond those set by reset.

Structure
REQ-027 The package dmem_arb_pkg SHALL hold the FSM state enum (ARB, LOCK0, LOCK1), port index constants (PORT_CPU=0, PORT_DMA=1), and the LOCK_MAX default.
REQ-028 The block SHALL contain one sub-module, dmem_arb_rr: a 2-way round-robin picker with inputs req[1:0] and prio, output gnt[1:0], purely combinational; the FSM, counter and response pipeline SHALL remain in dmem_arbiter.
REQ-029 The response pipeline SHALL be one register stage of {valid, owner} feeding rvalid/rdata.
REQ-030 The expected size of the RTL SHALL be 150-250 lines.

Verification
REQ-031 The bench SHALL check a single read: req0 read of addr 0x010 (holding 0xDEADBEEF) -> gnt0 in the same cycle, then rvalid0=1 and rdata0=0xDEADBEEF on the next cycle, with rvalid1 held at 0.
REQ-032 The bench SHALL check alternation: req0 and req1 held high for 4 cycles after reset -> grants 0,1,0,1, one per cycle, with mem_addr following each grant.
REQ-033 The bench SHALL check write then read: port1 writes 0x00000055 to 0xFFF, then reads 0xFFF in the next cycle -> rvalid1 with 0x00000055.
REQ-034 The bench SHALL check locking: port0 issues 3 locked reads then 1 unlocked read while req1 is held high -> port1 is granted only after the unlocked read; with LOCK_MAX=4 and lock0 held high, port1 is granted after exactly 4 port0 grants.
REQ-035 The bench SHALL check reset mid-operation: rst_n=0 in a cycle where a port0 read is granted and the FSM is in LOCK0 -> no rvalid next cycle, mem_we=0, FSM=ARB, and the first contended grant after reset goes to port 0.
